// File: rtl/div_iter32_pkg.sv
// Shared definitions for the iterative 32-bit divider: operand width and
// the FSM state encodings.
package div_iter32_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] DIVST_IDLE = 2'd0;
  localparam logic [1:0] DIVST_RUN  = 2'd1;
  localparam logic [1:0] DIVST_DONE = 2'd2;

endpackage

// File: rtl/div_iter32_if.sv
// MDU <-> divider bundle: operands and start strobe in, quotient/remainder
// and busy/over status back; the MDU holds off on busy and captures on over.
interface div_iter32_if;
  import div_iter32_pkg::*;

  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [DIV_WIDTH-1:0] q;
  logic [DIV_WIDTH-1:0] r;
  logic                 busy;
  logic                 over;

  modport master (
    output start, dividend, divisor,
    input  q, r, busy, over
  );

  modport slave (
    input  start, dividend, divisor,
    output q, r, busy, over
  );

endinterface

// File: rtl/div_iter32.sv
// Restoring divider, one quotient bit per cycle: result 33 edges after start with
// a one-cycle over pulse; start is only honoured in IDLE, never queued.
module div_iter32
  import div_iter32_pkg::*;
#(
  parameter bit SIGNED = 1'b1
) (
  input logic        clock,
  input logic        reset,
  div_iter32_if.slave div
);

  logic [1:0]           state;
  logic [4:0]           cnt;
  logic [DIV_WIDTH:0]   rem;
  logic [DIV_WIDTH-1:0] quo;
  logic [DIV_WIDTH-1:0] dvs;
  logic                 qneg;
  logic                 rneg;
  logic [DIV_WIDTH-1:0] q_reg;
  logic [DIV_WIDTH-1:0] r_reg;

  logic                 a_neg;
  logic                 b_neg;
  logic [DIV_WIDTH-1:0] a_mag;
  logic [DIV_WIDTH-1:0] b_mag;

  logic [DIV_WIDTH+1:0] rem_sh;
  logic [DIV_WIDTH-1:0] quo_sh;
  logic [DIV_WIDTH+1:0] trial;
  logic [DIV_WIDTH:0]   rem_nx;
  logic [DIV_WIDTH-1:0] quo_nx;
  logic                 last_iter;

  // 0x80000000 negates to itself, which is exactly the unsigned magnitude needed.
  assign a_neg = SIGNED && div.dividend[DIV_WIDTH-1];
  assign b_neg = SIGNED && div.divisor[DIV_WIDTH-1];
  assign a_mag = a_neg ? (~div.dividend + 32'd1) : div.dividend;
  assign b_mag = b_neg ? (~div.divisor + 32'd1) : div.divisor;

  // rem stays below the divisor after each restore, so rem_sh[33] is always 0
  // and trial[33] is a clean borrow flag.
  always_comb begin
    rem_sh = {rem, quo[DIV_WIDTH-1]};
    quo_sh = {quo[DIV_WIDTH-2:0], 1'b0};
    trial  = rem_sh - {2'b00, dvs};
    if (!trial[DIV_WIDTH+1]) begin
      rem_nx = trial[DIV_WIDTH:0];
      quo_nx = quo_sh | 32'd1;
    end else begin
      rem_nx = rem_sh[DIV_WIDTH:0];
      quo_nx = quo_sh;
    end
  end

  assign last_iter = (cnt == 5'd31);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= DIVST_IDLE;
      cnt   <= 5'd0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      q_reg <= '0;
      r_reg <= '0;
    end else begin
      case (state)
        DIVST_IDLE: begin
          if (div.start) begin
            state <= DIVST_RUN;
            cnt   <= 5'd0;
            rem   <= '0;
            quo   <= a_mag;
            dvs   <= b_mag;
            qneg  <= a_neg ^ b_neg;
            rneg  <= a_neg;
          end
        end
        DIVST_RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 5'd1;
          if (last_iter) begin
            state <= DIVST_DONE;
            q_reg <= qneg ? (~quo_nx + 32'd1) : quo_nx;
            r_reg <= rneg ? (~rem_nx[DIV_WIDTH-1:0] + 32'd1) : rem_nx[DIV_WIDTH-1:0];
          end
        end
        // Start is deliberately dropped here: the MDU's start is still high
        // with stale operands on the cycle it consumes the result.
        DIVST_DONE: state <= DIVST_IDLE;
        default:    state <= DIVST_IDLE;
      endcase
    end
  end

  assign div.q    = q_reg;
  assign div.r    = r_reg;
  assign div.busy = (state == DIVST_RUN);
  assign div.over = (state == DIVST_DONE);

endmodule

// File: tb/tb_div_iter32.sv
// Bench for div_iter32: directed vector table, randomized divides against a
// plain-arithmetic model, async reset mid-divide, and start held across DONE.
module tb_div_iter32;

  logic clk = 1'b0;
  logic rst_s;
  logic rst_u;

  always #5 clk = ~clk;

  div_iter32_if if_s ();
  div_iter32_if if_u ();

  div_iter32 #(.SIGNED(1'b1)) dut_s (.clock(clk), .reset(rst_s), .div(if_s));
  div_iter32 #(.SIGNED(1'b0)) dut_u (.clock(clk), .reset(rst_u), .div(if_u));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit s, input logic st, input logic [31:0] a, input logic [31:0] b);
    if (s) begin
      if_s.start = st; if_s.dividend = a; if_s.divisor = b;
    end else begin
      if_u.start = st; if_u.dividend = a; if_u.divisor = b;
    end
  endtask

  function automatic logic rd_busy(input bit s);
    return s ? if_s.busy : if_u.busy;
  endfunction
  function automatic logic rd_over(input bit s);
    return s ? if_s.over : if_u.over;
  endfunction
  function automatic logic [31:0] rd_q(input bit s);
    return s ? if_s.q : if_u.q;
  endfunction
  function automatic logic [31:0] rd_r(input bit s);
    return s ? if_s.r : if_u.r;
  endfunction

  // Architectural DIV/DIVU results, including the divide-by-zero and overflow cases.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = (s && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called #1 after a clock edge; returns one edge after over was seen.
  task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r,
                         output int edges, output int busy_n, output logic over_after);
    drive(s, 1'b1, a, b);
    @(posedge clk); #1;
    drive(s, 1'b0, a, b);
    busy_n = rd_busy(s) ? 1 : 0;
    edges  = 0;
    while (!rd_over(s) && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      busy_n += rd_busy(s) ? 1 : 0;
    end
    q = rd_q(s);
    r = rd_r(s);
    @(posedge clk); #1;
    over_after = rd_over(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, eq, er, a, b;
    logic        ov;
    int          edges, busy_n, hits;
    bit          s;

    vecs[0] = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{1'b1, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vecs[2] = '{1'b1, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF,  32'd2,          32'h7FFF_FFFF,  32'd1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF,  32'd2,          32'd0,          32'hFFFF_FFFF};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          32'd1,          32'hFFFF_FFFB};
    vecs[7] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5};
    vecs[8] = '{1'b1, 32'd7,          32'd0,          32'hFFFF_FFFF,  32'd7};
    vecs[9] = '{1'b0, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_DEAD,  32'h0000_BEEF};

    rst_s = 1'b1;
    rst_u = 1'b1;
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("reset_busy", {31'd0, if_s.busy}, 32'd0);
    check("reset_over", {31'd0, if_s.over}, 32'd0);
    check("reset_q",    if_s.q, 32'd0);
    check("reset_r",    if_u.r, 32'd0);
    @(posedge clk); #1;
    rst_s = 1'b0;
    rst_u = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, edges, busy_n, ov);
      check($sformatf("vec%0d_q", i), q, vecs[i].q);
      check($sformatf("vec%0d_r", i), r, vecs[i].r);
      check($sformatf("vec%0d_latency", i), 32'(edges), 32'd32);
      check($sformatf("vec%0d_busy_cycles", i), 32'(busy_n), 32'd32);
      check($sformatf("vec%0d_over_pulse", i), {31'd0, ov}, 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      s = (i % 2) == 0;
      a = $urandom();
      case ($urandom_range(0, 5))
        0:       b = $urandom();
        1:       b = $urandom_range(1, 20);
        2:       b = 32'd0 - $urandom_range(1, 20);
        3:       b = $urandom() >> $urandom_range(1, 31);
        4:       b = (i % 16 == 4) ? 32'd0 : 32'hFFFF_FFFF;
        default: b = $urandom_range(1, 65535);
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      ref_div(s, a, b, eq, er);
      run_div(s, a, b, q, r, edges, busy_n, ov);
      check($sformatf("rnd%0d_q a=%08h b=%08h s=%0d", i, a, b, s), q, eq);
      check($sformatf("rnd%0d_r a=%08h b=%08h s=%0d", i, a, b, s), r, er);
      if (i % 50 == 0) check($sformatf("rnd%0d_latency", i), 32'(edges), 32'd32);
    end

    // Async reset mid-divide clears outputs without an edge.
    run_div(1'b1, 32'd100, 32'd7, q, r, edges, busy_n, ov);
    drive(1'b1, 1'b1, 32'd1000, 32'd3);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    check("rst_pre_busy", {31'd0, if_s.busy}, 32'd1);
    check("rst_pre_q",    if_s.q, 32'd14);
    rst_s = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, if_s.busy}, 32'd0);
    check("rst_mid_over", {31'd0, if_s.over}, 32'd0);
    check("rst_mid_q",    if_s.q, 32'd0);
    check("rst_mid_r",    if_s.r, 32'd0);
    @(posedge clk); #1;
    rst_s = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if_s.busy || if_s.over) hits++;
    end
    check("rst_stays_idle", 32'(hits), 32'd0);

    // Start held high through DONE: the second divide must wait for IDLE.
    drive(1'b1, 1'b1, 32'd20, 32'd6);
    @(posedge clk); #1;
    edges = 0;
    while (!if_s.over && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    check("b2b_first_latency", 32'(edges), 32'd32);
    check("b2b_first_q", if_s.q, 32'd3);
    check("b2b_first_r", if_s.r, 32'd2);
    drive(1'b1, 1'b1, 32'd9, 32'd4);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
      if (edges == 3) begin
        check("b2b_busy_second", {31'd0, if_s.busy}, 32'd1);
        check("b2b_q_held", if_s.q, 32'd3);
      end
    end while (!if_s.over && edges < 100);
    check("b2b_over_spacing", 32'(edges), 32'd34);
    check("b2b_second_q", if_s.q, 32'd2);
    check("b2b_second_r", if_s.r, 32'd1);
    drive(1'b1, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_iter32.md
# div_iter32

Iterative 32-bit restoring divider serving the multiply/divide unit's DIV and DIVU instructions. The MDU feeds it operands and a start strobe, stalls the PC until `over`, and captures `q`/`r` into LO/HI. One bit of quotient is produced per cycle. A parameter selects signed (DIV) or unsigned (DIVU) semantics, so the MDU instantiates it twice.

## Interface
- `SIGNED`, default 1: 1 gives MIPS DIV semantics (two's complement); 0 gives DIVU semantics (unsigned).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high. The MDU holds it high whenever the current op is not this divider's op.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  32  numerator (rs); sampled with `start`.
- `divisor`  in  32  denominator (rt); sampled with `start`.
- `q`  out  32  quotient; MDU routes it to LO.
- `r`  out  32  remainder; MDU routes it to HI.
- `busy`  out  1  high while iterating.
- `over`  out  1  one-cycle completion pulse.

## Operation
- **Reset values:** `q`=0, `r`=0, `busy`=0, `over`=0; state IDLE; counter 0. Reset takes effect immediately at any point, including mid-division, and discards the partial result.
- **States:**
  - IDLE → RUN on `start`.
  - RUN → RUN while counter < 31.
  - RUN → DONE on the 32nd iteration edge.
  - DONE → IDLE unconditionally.
- **IDLE + start:** latch the operand magnitudes.
  - SIGNED=1: magnitudes are |dividend| and |divisor| as 32-bit unsigned, so 0x80000000 maps to itself.
  - Latch `qneg` = sign(dividend) XOR sign(divisor).
  - Latch `rneg` = sign(dividend).
  - SIGNED=0: both sign flags are 0.
  - Clear the 33-bit partial remainder; load the quotient shift register with |dividend|; set counter 0.
- **RUN, each cycle:**
  - Shift {rem, quo} left by 1.
  - Trial = rem[32:0] − {1'b0, |divisor|}.
  - If the trial is non-negative: rem ← trial and quotient LSB ← 1. Otherwise the quotient LSB is 0.
  - Counter increments.
- **Final edge (32nd iteration):**
  - `q` ← qneg ? −quo : quo.
  - `r` ← rneg ? −rem[31:0] : rem[31:0].
  - Rounding: quotient truncates toward zero; the remainder carries the dividend's sign.
- **`q`/`r` hold** from the final edge until the next reset or the next final edge. They are not cleared by `start`.
- **`busy`** = 1 exactly in RUN. **`over`** = 1 exactly in DONE.
- **`start` is ignored in DONE.** This prevents the MDU (start = op && !busy) from relaunching with stale operands on the cycle its PC advances.
- **Divide by zero:** no trap; the result is whatever the datapath naturally produces.
  - Magnitude quotient = 0xFFFFFFFF, remainder = |dividend|, then sign correction applies.
  - Unsigned: q=0xFFFFFFFF, r=dividend.
  - Signed: q = (dividend<0) ? 1 : 0xFFFFFFFF; r = dividend.
- **Overflow:** signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0, with no flag.

## Timing
- `start` is sampled at edge E0. `busy`=1 from E0 through E32 (32 cycles). State is DONE with `over`=1 after E32 for exactly one cycle, then IDLE after E33.
- `q`/`r` are valid from E32, concurrently with `over`. The MDU writes {LO,HI} and advances the PC at E33.
- Back-to-back divides: a new `start` is accepted in IDLE at E33, so the next result arrives 33 cycles later. The minimum issue interval is 34 cycles.
- `start` asserted while `busy`: ignored. The operands are not re-sampled.
- `reset` asserted in any cycle forces all outputs to their reset values without waiting for a clock edge. A `start` in the same cycle is lost.

## Structure
- Shared definitions go in the common definitions header: state encodings `DIVST_IDLE`/`DIVST_RUN`/`DIVST_DONE` (2 bits) and `DIV_WIDTH` = 32.
- Single module, with no sub-module. Negate and absolute-value logic is inline two's-complement arithmetic, used on both the input and output sides.
- The counter is 5 bits plus a terminal-count compare.

## Test plan
- SIGNED=1, 100 / 7 → after 33 cycles `over`=1, q=14, r=2; `busy` high for exactly 32 cycles.
- SIGNED=1, −100 / 7 → q=0xFFFFFFF2, r=0xFFFFFFFE. Also 100 / −7 → q=0xFFFFFFF2, r=2.
- SIGNED=0, 0xFFFFFFFF / 2 → q=0x7FFFFFFF, r=1. SIGNED=1 with the same operands (−1 / 2) → q=0, r=0xFFFFFFFF.
- SIGNED=1, 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. Divide by zero, −5 / 0 → q=1, r=0xFFFFFFFB.
- Start 1000 / 3, assert `reset` at cycle 10 → `busy`, `over`, `q` and `r` go to 0 immediately. After release, with no start, the block stays idle.
- Hold `start` high continuously across two divides (20/6, then 9/4 presented after DONE) → the start in DONE is ignored. Results are q=3, r=2 at the first `over` and q=2, r=1 at the second `over`, 34 cycles apart.
